// File: rtl/ijvm_bus_sequencer_if.sv
// Bus bundle between the microinstruction source / memory side and the
// IJVM bus sequencer.
//
// Handshake: a microinstruction transfers on a rising clock edge where
// uop_valid && uop_ready are both high. uop_ready does not depend on
// uop_valid. The memory request (mem_rd/mem_wr/mem_fetch) is held until
// mem_ack is seen high on a rising edge or the sequencer times out. mem_ack
// is a single-cycle pulse and is ignored while no request is outstanding.
interface ijvm_bus_sequencer_if #(
   parameter int NUM_B = 9,
   parameter int NUM_C = 9,
   parameter int SEL_W = 4
);
   logic             uop_valid;
   logic             uop_ready;
   logic [SEL_W-1:0] uop_b_sel;
   logic [NUM_C-1:0] uop_c_mask;
   logic [1:0]       uop_mem;
   logic [NUM_B-1:0] b_read_enable;
   logic [NUM_C-1:0] c_write_enable;
   logic             mem_rd;
   logic             mem_wr;
   logic             mem_fetch;
   logic             mem_ack;
   logic             busy;
   logic             sel_err;
   logic             mem_err;

   // Microinstruction source and memory side.
   modport master (
      output uop_valid, uop_b_sel, uop_c_mask, uop_mem, mem_ack,
      input  uop_ready, b_read_enable, c_write_enable, mem_rd, mem_wr,
             mem_fetch, busy, sel_err, mem_err
   );

   // Sequencer side.
   modport slave (
      input  uop_valid, uop_b_sel, uop_c_mask, uop_mem, mem_ack,
      output uop_ready, b_read_enable, c_write_enable, mem_rd, mem_wr,
             mem_fetch, busy, sel_err, mem_err
   );
endinterface

// File: rtl/ijvm_bus_sequencer.sv
// IJVM bus sequencer: runs one microinstruction at a time. The B source is
// enabled for ALU_CYCLES cycles, the C destinations are written in the last
// of those cycles, then the optional memory operation is issued and held
// until mem_ack or a timeout. All outputs decode from registered state, so
// they only change at posedge and are stable when registers drive B at
// negedge.
module ijvm_bus_sequencer #(
   parameter int NUM_B       = 9,
   parameter int NUM_C       = 9,
   parameter int SEL_W       = 4,
   parameter int ALU_CYCLES  = 1,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   ijvm_bus_sequencer_if.slave  bus,
   output logic [1:0]           state_o
);

   localparam int CNT_W = (ALU_CYCLES > 1) ? $clog2(ALU_CYCLES) : 1;
   localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_MEM  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [SEL_W-1:0] b_sel_q, b_sel_d;
   logic [NUM_C-1:0] c_mask_q, c_mask_d;
   logic [1:0]       mem_q, mem_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             sel_err_q, sel_err_d;
   logic             mem_err_q, mem_err_d;

   logic             accept;
   logic             in_sel_ok;
   logic             q_sel_ok;
   logic [TMO_W-1:0] tmo_dec;

   assign accept    = bus.uop_valid && (state_q == S_IDLE);
   assign in_sel_ok = int'(bus.uop_b_sel) < NUM_B;
   assign q_sel_ok  = int'(b_sel_q) < NUM_B;
   assign tmo_dec   = tmo_q - TMO_W'(1);

   // State and latched microinstruction registers, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         b_sel_q   <= '0;
         c_mask_q  <= '0;
         mem_q     <= '0;
         cnt_q     <= '0;
         tmo_q     <= '0;
         sel_err_q <= 1'b0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         b_sel_q   <= b_sel_d;
         c_mask_q  <= c_mask_d;
         mem_q     <= mem_d;
         cnt_q     <= cnt_d;
         tmo_q     <= tmo_d;
         sel_err_q <= sel_err_d;
         mem_err_q <= mem_err_d;
      end
   end

   // Next-state logic and bus enable decode.
   always_comb begin
      state_d            = state_q;
      b_sel_d            = b_sel_q;
      c_mask_d           = c_mask_q;
      mem_d              = mem_q;
      cnt_d              = cnt_q;
      tmo_d              = tmo_q;
      sel_err_d          = sel_err_q;
      mem_err_d          = mem_err_q;
      bus.b_read_enable  = '0;
      bus.c_write_enable = '0;
      bus.mem_rd         = 1'b0;
      bus.mem_wr         = 1'b0;
      bus.mem_fetch      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d  = S_EXEC;
               b_sel_d  = bus.uop_b_sel;
               c_mask_d = bus.uop_c_mask;
               mem_d    = bus.uop_mem;
               cnt_d    = CNT_W'(ALU_CYCLES - 1);
               // A write with no B source would capture a floating bus.
               if (!in_sel_ok && (bus.uop_c_mask != '0)) begin
                  sel_err_d = 1'b1;
               end
            end
         end

         S_EXEC: begin
            if (q_sel_ok) begin
               bus.b_read_enable = NUM_B'(1) << b_sel_q;
            end
            if (cnt_q == '0) begin
               // C capture lands at the posedge closing this cycle, before
               // memory sees MAR/MDR.
               bus.c_write_enable = c_mask_q;
               if (mem_q == 2'b00) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_MEM;
                  tmo_d   = TMO_W'(MEM_TIMEOUT);
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         S_MEM: begin
            bus.mem_rd    = (mem_q == 2'b01);
            bus.mem_wr    = (mem_q == 2'b10);
            bus.mem_fetch = (mem_q == 2'b11);
            tmo_d         = tmo_dec;
            if (bus.mem_ack) begin
               state_d = S_IDLE;
            end else if (tmo_dec == '0) begin
               state_d   = S_IDLE;
               mem_err_d = 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.uop_ready = (state_q == S_IDLE);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.sel_err   = sel_err_q;
   assign bus.mem_err   = mem_err_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_ijvm_bus_sequencer.sv
// Bench for ijvm_bus_sequencer: one instance with ALU_CYCLES=1 (bus_a) for
// the table of single microinstructions, memory handshakes, timeout and
// reset-in-MEM, and one with ALU_CYCLES=3 (bus_b) for the multi-cycle EXEC
// window and reset-in-EXEC. Inputs change and outputs are sampled at negedge.
module tb_ijvm_bus_sequencer;

   localparam int OBS_W = 25;

   logic clk;
   logic rst;
   logic [1:0] state_a;
   logic [1:0] state_b;

   ijvm_bus_sequencer_if #(.NUM_B(9), .NUM_C(9), .SEL_W(4)) bus_a ();
   ijvm_bus_sequencer_if #(.NUM_B(9), .NUM_C(9), .SEL_W(4)) bus_b ();

   ijvm_bus_sequencer #(
      .NUM_B(9), .NUM_C(9), .SEL_W(4), .ALU_CYCLES(1), .MEM_TIMEOUT(15)
   ) u_dut_a (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus_a.slave),
      .state_o (state_a)
   );

   ijvm_bus_sequencer #(
      .NUM_B(9), .NUM_C(9), .SEL_W(4), .ALU_CYCLES(3), .MEM_TIMEOUT(15)
   ) u_dut_b (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus_b.slave),
      .state_o (state_b)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   logic [OBS_W-1:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   logic se_a = 1'b0;
   logic me_a = 1'b0;

   function automatic logic [OBS_W-1:0] mk(input logic rdy, input logic [8:0] b,
                                           input logic [8:0] c, input logic rd,
                                           input logic wr, input logic fe,
                                           input logic se, input logic me);
      return {rdy, ~rdy, b, c, rd, wr, fe, se, me};
   endfunction

   function automatic logic [OBS_W-1:0] snap_a();
      return {bus_a.uop_ready, bus_a.busy, bus_a.b_read_enable, bus_a.c_write_enable,
              bus_a.mem_rd, bus_a.mem_wr, bus_a.mem_fetch, bus_a.sel_err, bus_a.mem_err};
   endfunction

   function automatic logic [OBS_W-1:0] snap_b();
      return {bus_b.uop_ready, bus_b.busy, bus_b.b_read_enable, bus_b.c_write_enable,
              bus_b.mem_rd, bus_b.mem_wr, bus_b.mem_fetch, bus_b.sel_err, bus_b.mem_err};
   endfunction

   task automatic check(input string name, input logic [OBS_W-1:0] act);
      logic [OBS_W-1:0] e;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: no expected entry, got %h", name, act);
      end else begin
         e = exp_q.pop_front();
         if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got rdy/busy/b/c/rd/wr/fe/se/me=%h required %h", name, act, e);
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_a(input logic [3:0] bs, input logic [8:0] cm, input logic [1:0] mm);
      bus_a.uop_valid  = 1'b1;
      bus_a.uop_b_sel  = bs;
      bus_a.uop_c_mask = cm;
      bus_a.uop_mem    = mm;
   endtask

   // Called at a negedge with DUT A idle; returns at the negedge where A is idle again.
   task automatic run_uop_a(input string name, input logic [3:0] bs, input logic [8:0] cm,
                            input logic [1:0] mm, input int ack_after,
                            input logic [8:0] eb, input logic [8:0] ec);
      exp_q.push_back(mk(1'b1, 9'h0, 9'h0, 1'b0, 1'b0, 1'b0, se_a, me_a));
      check({name, " idle"}, snap_a());
      drive_a(bs, cm, mm);
      @(negedge clk);
      if (bs >= 4'd9 && cm != 9'h0) se_a = 1'b1;
      exp_q.push_back(mk(1'b0, eb, ec, 1'b0, 1'b0, 1'b0, se_a, me_a));
      check({name, " exec"}, snap_a());
      // Inputs seen while busy must be ignored.
      bus_a.uop_valid  = 1'($urandom_range(0, 1));
      bus_a.uop_b_sel  = 4'($urandom_range(0, 15));
      bus_a.uop_c_mask = 9'($urandom_range(0, 511));
      bus_a.uop_mem    = 2'($urandom_range(0, 3));
      if (mm != 2'b00) begin
         for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            exp_q.push_back(mk(1'b0, 9'h0, 9'h0, mm == 2'b01, mm == 2'b10, mm == 2'b11,
                               se_a, me_a));
            check({name, " mem"}, snap_a());
            if (k == ack_after) begin
               bus_a.mem_ack = 1'b1;
               break;
            end
         end
         bus_a.uop_valid = 1'b0;
         @(negedge clk);
         bus_a.mem_ack = 1'b0;
         if (ack_after < 1 || ack_after > 15) me_a = 1'b1;
      end else begin
         bus_a.uop_valid = 1'b0;
         @(negedge clk);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      string      name;
      logic [3:0] bs;
      logic [8:0] cm;
      logic [1:0] mm;
      int         ack;
      logic [8:0] eb;
      logic [8:0] ec;
   } vec_t;

   vec_t tbl[10];

   initial begin
      logic [3:0] rbs;
      logic [8:0] rcm;
      logic [1:0] rmm;
      logic [8:0] reb;
      logic [8:0] rec;

      tbl[0] = '{"tos_to_h",      4'd7,  9'h001, 2'b00, 0,  9'h080, 9'h001};
      tbl[1] = '{"mdr_to_mdr",    4'd0,  9'h080, 2'b00, 0,  9'h001, 9'h080};
      tbl[2] = '{"mbr_to_all",    4'd2,  9'h1FF, 2'b00, 0,  9'h004, 9'h1FF};
      tbl[3] = '{"opc_no_dest",   4'd8,  9'h000, 2'b00, 0,  9'h100, 9'h000};
      tbl[4] = '{"rd_ack4",       4'd1,  9'h100, 2'b01, 4,  9'h002, 9'h100};
      tbl[5] = '{"fetch_ack1",    4'd4,  9'h020, 2'b11, 1,  9'h010, 9'h020};
      tbl[6] = '{"nosrc_nomask",  4'd15, 9'h000, 2'b00, 0,  9'h000, 9'h000};
      tbl[7] = '{"sel9_mask",     4'd9,  9'h002, 2'b00, 0,  9'h000, 9'h002};
      tbl[8] = '{"selF_mask",     4'd15, 9'h004, 2'b00, 0,  9'h000, 9'h004};
      tbl[9] = '{"wr_ack15",      4'd5,  9'h010, 2'b10, 15, 9'h020, 9'h010};

      rst = 1'b1;
      bus_a.uop_valid = 1'b0; bus_a.uop_b_sel = '0; bus_a.uop_c_mask = '0;
      bus_a.uop_mem = '0;     bus_a.mem_ack = 1'b0;
      bus_b.uop_valid = 1'b0; bus_b.uop_b_sel = '0; bus_b.uop_c_mask = '0;
      bus_b.uop_mem = '0;     bus_b.mem_ack = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state of both instances.
      exp_q.push_back(mk(1'b1, 9'h0, 9'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      check("reset_a", snap_a());
      exp_q.push_back(mk(1'b1, 9'h0, 9'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      check("reset_b", snap_b());
      rst = 1'b0;
      @(negedge clk);

      // ALU_CYCLES=3: B held three cycles, C only in the third.
      bus_b.uop_valid = 1'b1; bus_b.uop_b_sel = 4'd1; bus_b.uop_c_mask = 9'h040;
      bus_b.uop_mem = 2'b00;
      @(negedge clk);
      bus_b.uop_valid = 1'b0;
      exp_q.push_back(mk(1'b0, 9'h002, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      check("b3_exec1", snap_b());
      @(negedge clk);
      exp_q.push_back(mk(1'b0, 9'h002, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      check("b3_exec2", snap_b());
      @(negedge clk);
      exp_q.push_back(mk(1'b0, 9'h002, 9'h040, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      check("b3_exec3", snap_b());
      @(negedge clk);
      exp_q.push_back(mk(1'b1, 9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      check("b3_idle", snap_b());

      // Reset during EXEC clears the sticky sel_err and aborts the uop.
      bus_b.uop_valid = 1'b1; bus_b.uop_b_sel = 4'd15; bus_b.uop_c_mask = 9'h001;
      bus_b.uop_mem = 2'b01;
      @(negedge clk);
      bus_b.uop_valid = 1'b0;
      exp_q.push_back(mk(1'b0, 9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
      check("b3_selerr_exec1", snap_b());
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back(mk(1'b1, 9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      check("b3_rst_exec", snap_b());
      @(negedge clk);
      exp_q.push_back(mk(1'b1, 9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      check("b3_rst_noretry", snap_b());

      // Table of single uops on the ALU_CYCLES=1 instance, back to back.
      for (int i = 0; i < 10; i++) begin
         run_uop_a(tbl[i].name, tbl[i].bs, tbl[i].cm, tbl[i].mm, tbl[i].ack,
                   tbl[i].eb, tbl[i].ec);
      end

      // mem_ack while idle is ignored.
      bus_a.mem_ack = 1'b1;
      @(negedge clk);
      bus_a.mem_ack = 1'b0;
      exp_q.push_back(mk(1'b1, 9'h0, 9'h0, 1'b0, 1'b0, 1'b0, se_a, me_a));
      check("ack_idle", snap_a());

      // Write with no ack: 15 request cycles, then sticky mem_err.
      run_uop_a("wr_timeout", 4'd6, 9'h000, 2'b10, 0, 9'h040, 9'h000);
      run_uop_a("after_tmo", 4'd3, 9'h008, 2'b00, 0, 9'h008, 9'h008);

      // Random uops with prompt acks.
      for (int i = 0; i < 20; i++) begin
         rbs = 4'($urandom_range(0, 15));
         rcm = 9'($urandom_range(0, 511));
         rmm = 2'($urandom_range(0, 3));
         reb = (rbs < 4'd9) ? (9'h001 << rbs) : 9'h000;
         rec = rcm;
         run_uop_a("rand", rbs, rcm, rmm, $urandom_range(1, 6), reb, rec);
      end

      // Reset during MEM: requests drop, flags clear, nothing retried.
      exp_q.push_back(mk(1'b1, 9'h0, 9'h0, 1'b0, 1'b0, 1'b0, se_a, me_a));
      check("pre_rst_mem idle", snap_a());
      drive_a(4'd0, 9'h100, 2'b01);
      @(negedge clk);
      bus_a.uop_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      exp_q.push_back(mk(1'b0, 9'h0, 9'h0, 1'b1, 1'b0, 1'b0, se_a, me_a));
      check("pre_rst_mem rd", snap_a());
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      se_a = 1'b0;
      me_a = 1'b0;
      exp_q.push_back(mk(1'b1, 9'h0, 9'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      check("rst_mem", snap_a());
      @(negedge clk);
      exp_q.push_back(mk(1'b1, 9'h0, 9'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      check("rst_mem_noretry", snap_a());
      run_uop_a("post_rst", 4'd7, 9'h001, 2'b00, 0, 9'h080, 9'h001);
      exp_q.push_back(mk(1'b1, 9'h0, 9'h0, 1'b0, 1'b0, 1'b0, se_a, me_a));
      check("final_idle", snap_a());

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
